// File: rtl/keypad_def_pkg.sv
// Shared definitions for the hex keypad scanner.
// Holds the FSM states, scan-result codes and the row/column key map.
package keypad_def_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DEB_PRESS,
      ST_PRESSED,
      ST_DEB_REL
   } state_t;

   typedef enum logic [1:0] {
      RES_NONE,
      RES_SINGLE,
      RES_MULTI
   } res_t;

   // Nibble i holds the code of key (row i/4, col i%4).
   localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

   function automatic logic [3:0] key_lookup(
      input logic [1:0] r,
      input logic [1:0] c
   );
      logic [5:0] base;
      base = {r, c, 2'b00};
      return KEY_MAP[base +: 4];
   endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// Two-flop synchronizer for the four active-low keypad columns.
// Ports: clk, reset (sync, active-low), col_n (async in), col_s (synced out).
module keypad_col_sync (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] col_n,
   output logic [3:0] col_s
);

   logic [3:0] meta;

   always_ff @(posedge clk) begin
      if (!reset) begin
         meta  <= 4'hF;
         col_s <= 4'hF;
      end else begin
         meta  <= col_n;
         col_s <= meta;
      end
   end

endmodule

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: row scan, debounce FSM, key_valid/ack handshake.
// Ports: clk, reset (sync, active-low), col_n, key_ack in; row_n,
// key_code, key_valid, key_pressed, overrun out.
module hex_keypad_scanner
   import keypad_def_pkg::*;
#(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] col_n,
   input  logic       key_ack,
   output logic [3:0] row_n,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_pressed,
   output logic       overrun
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SCANS - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [3:0]    col_s;
   logic [DW-1:0] div;
   logic [1:0]    ri;
   logic [1:0]    nlow;
   logic [3:0]    acode;
   res_t          res;
   logic [3:0]    res_code;
   logic          scan_end;
   state_t        state;
   logic [3:0]    cand;
   logic [CW-1:0] cnt;
   logic          ev;

   logic [3:0]    low;
   logic [1:0]    rn;
   logic [1:0]    rc;
   logic [1:0]    tn;
   logic [3:0]    tcode;
   res_t          nres;

   keypad_col_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .col_n (col_n),
      .col_s (col_s)
   );

   // Fold the current row into the running scan tally.
   // Low-bit counts saturate at 2, which already means MULTI.
   always_comb begin
      low = ~col_s;
      rn  = 2'd0;
      rc  = 2'd0;
      for (int c = 0; c < 4; c++) begin
         if (low[c]) begin
            if (rn != 2'd2) rn = rn + 2'd1;
            rc = 2'(c);
         end
      end
      if (nlow == 2'd0) begin
         tn    = rn;
         tcode = key_lookup(ri, rc);
      end else if (rn == 2'd0) begin
         tn    = nlow;
         tcode = acode;
      end else begin
         tn    = 2'd2;
         tcode = acode;
      end
      case (tn)
         2'd0:    nres = RES_NONE;
         2'd1:    nres = RES_SINGLE;
         default: nres = RES_MULTI;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         div      <= '0;
         ri       <= 2'd0;
         row_n    <= 4'b1110;
         nlow     <= 2'd0;
         acode    <= 4'h0;
         res      <= RES_NONE;
         res_code <= 4'h0;
         scan_end <= 1'b0;
      end else begin
         scan_end <= 1'b0;
         if (div == DIV_LAST) begin
            div   <= '0;
            ri    <= ri + 2'd1;
            row_n <= {row_n[2:0], row_n[3]};
            if (ri == 2'd3) begin
               res      <= nres;
               res_code <= tcode;
               scan_end <= 1'b1;
               nlow     <= 2'd0;
            end else begin
               nlow  <= tn;
               acode <= tcode;
            end
         end else begin
            div <= div + DW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= ST_IDLE;
         cand        <= 4'h0;
         cnt         <= '0;
         key_pressed <= 1'b0;
         ev          <= 1'b0;
      end else begin
         ev <= 1'b0;
         if (scan_end) begin
            unique case (state)
               ST_IDLE: begin
                  if (res == RES_SINGLE) begin
                     cand <= res_code;
                     cnt  <= CNT_ONE;
                     if (DEBOUNCE_SCANS == 1) begin
                        state       <= ST_PRESSED;
                        key_pressed <= 1'b1;
                        ev          <= 1'b1;
                     end else begin
                        state <= ST_DEB_PRESS;
                     end
                  end
               end
               ST_DEB_PRESS: begin
                  if (res != RES_SINGLE) begin
                     state <= ST_IDLE;
                  end else if (res_code != cand) begin
                     cand <= res_code;
                     cnt  <= CNT_ONE;
                  end else if (cnt == CNT_LAST) begin
                     state       <= ST_PRESSED;
                     key_pressed <= 1'b1;
                     ev          <= 1'b1;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
               ST_PRESSED: begin
                  if (res == RES_NONE) begin
                     if (DEBOUNCE_SCANS == 1) begin
                        state       <= ST_IDLE;
                        key_pressed <= 1'b0;
                     end else begin
                        state <= ST_DEB_REL;
                        cnt   <= CNT_ONE;
                     end
                  end
               end
               ST_DEB_REL: begin
                  if (res != RES_NONE) begin
                     state <= ST_PRESSED;
                  end else if (cnt == CNT_LAST) begin
                     state       <= ST_IDLE;
                     key_pressed <= 1'b0;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   // A press event beats a same-cycle ack; otherwise a pending
   // code is never overwritten and the loss is flagged instead.
   always_ff @(posedge clk) begin
      if (!reset) begin
         key_code  <= 4'h0;
         key_valid <= 1'b0;
         overrun   <= 1'b0;
      end else if (ev) begin
         if (!key_valid || key_ack) begin
            key_code  <= cand;
            key_valid <= 1'b1;
         end else begin
            overrun <= 1'b1;
         end
      end else if (key_ack && key_valid) begin
         key_valid <= 1'b0;
         overrun   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Directed bench for hex_keypad_scanner with a 4x4 matrix model.
// SCAN_DIV=4, DEBOUNCE_SCANS=2: one full scan is 16 cycles.
module tb_hex_keypad_scanner;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] col_n;
   logic       key_ack = 1'b0;
   logic [3:0] row_n;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_pressed;
   logic       overrun;
   logic [15:0] held = 16'h0;

   int checks = 0;
   int errors = 0;

   hex_keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .col_n       (col_n),
      .key_ack     (key_ack),
      .row_n       (row_n),
      .key_code    (key_code),
      .key_valid   (key_valid),
      .key_pressed (key_pressed),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   always_comb begin
      col_n = 4'hF;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (!row_n[r] && held[r*4+c]) col_n[c] = 1'b0;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // sel 0: key_valid, sel 1: key_pressed
   task automatic wait_for(input int sel, input logic val,
                           input int bound, output int n,
                           output bit hit);
      logic cur;
      n   = 0;
      hit = 1'b0;
      while (n < bound) begin
         cur = (sel == 0) ? key_valid : key_pressed;
         if (cur === val) begin
            hit = 1'b1;
            break;
         end
         tick();
         n++;
      end
   endtask

   task automatic pulse_ack();
      key_ack = 1'b1;
      tick();
      key_ack = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      ticks(3);
      checks++;
      if (row_n !== 4'b1110) begin
         errors++;
         $display("FAIL reset_row got %b exp 1110", row_n);
      end
      checks++;
      if ({key_code, key_valid, key_pressed, overrun} !== 7'd0) begin
         errors++;
         $display("FAIL reset_outs got %h%b%b%b exp 0000",
                  key_code, key_valid, key_pressed, overrun);
      end
      reset = 1'b1;
      ticks(3);
      checks++;
      if (row_n !== 4'b1110) begin
         errors++;
         $display("FAIL row_hold3 got %b exp 1110", row_n);
      end
      tick();
      checks++;
      if (row_n !== 4'b1101) begin
         errors++;
         $display("FAIL row_after4 got %b exp 1101", row_n);
      end
      ticks(4);
      checks++;
      if (row_n !== 4'b1011) begin
         errors++;
         $display("FAIL row_after8 got %b exp 1011", row_n);
      end
   endtask

   task automatic test_single_press();
      int n;
      bit hit;
      held = 16'h0;
      held[6] = 1'b1;
      wait_for(0, 1'b1, 80, n, hit);
      checks++;
      if (!hit || n < 17 || n > 53) begin
         errors++;
         $display("FAIL press6_latency got %0d hit %0d exp 17..53", n, hit);
      end
      checks++;
      if (key_code !== 4'h6 || key_pressed !== 1'b1) begin
         errors++;
         $display("FAIL press6_code got %h/%b exp 6/1",
                  key_code, key_pressed);
      end
      ticks(12 * 16 - n);
      checks++;
      if (key_valid !== 1'b1 || overrun !== 1'b0 ||
          key_code !== 4'h6) begin
         errors++;
         $display("FAIL hold6_norepeat got %b%b%h exp 106",
                  key_valid, overrun, key_code);
      end
      held = 16'h0;
      wait_for(1, 1'b0, 80, n, hit);
      checks++;
      if (!hit || n < 17) begin
         errors++;
         $display("FAIL release6 got %0d hit %0d exp >=17", n, hit);
      end
      checks++;
      if (key_valid !== 1'b1 || key_code !== 4'h6) begin
         errors++;
         $display("FAIL release6_valid got %b/%h exp 1/6",
                  key_valid, key_code);
      end
      pulse_ack();
      checks++;
      if (key_valid !== 1'b0) begin
         errors++;
         $display("FAIL ack6 got %b exp 0", key_valid);
      end
   endtask

   task automatic test_bounce();
      int n;
      bit hit;
      bit seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         held = (i % 2 == 0) ? 16'h2000 : 16'h0000;
         for (int k = 0; k < 16; k++) begin
            tick();
            if (key_valid || key_pressed) seen = 1'b1;
         end
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL bounce_event got 1 exp 0");
      end
      held = 16'h2000;
      wait_for(0, 1'b1, 80, n, hit);
      checks++;
      if (!hit || n < 17) begin
         errors++;
         $display("FAIL bounce_stable got %0d hit %0d exp >=17", n, hit);
      end
      checks++;
      if (key_code !== 4'h0) begin
         errors++;
         $display("FAIL bounce_code got %h exp 0", key_code);
      end
      pulse_ack();
      held = 16'h0;
      wait_for(1, 1'b0, 80, n, hit);
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL bounce_release got timeout exp release");
      end
   endtask

   task automatic test_multi();
      bit seen = 1'b0;
      held = 16'h0401;
      for (int k = 0; k < 6 * 16; k++) begin
         tick();
         if (key_valid || key_pressed) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL multi_event got 1 exp 0");
      end
      held = 16'h0;
      ticks(40);
   endtask

   task automatic test_overrun();
      int n;
      bit hit;
      held = 16'h0020;
      wait_for(0, 1'b1, 80, n, hit);
      checks++;
      if (!hit || key_code !== 4'h5) begin
         errors++;
         $display("FAIL ovr_press5 got %h hit %0d exp 5", key_code, hit);
      end
      held = 16'h0;
      wait_for(1, 1'b0, 80, n, hit);
      held = 16'h0800;
      wait_for(1, 1'b1, 80, n, hit);
      ticks(3);
      checks++;
      if (!hit || key_code !== 4'h5 || overrun !== 1'b1 ||
          key_valid !== 1'b1) begin
         errors++;
         $display("FAIL ovr_pressC got %h/%b/%b exp 5/1/1",
                  key_code, overrun, key_valid);
      end
      pulse_ack();
      checks++;
      if (key_valid !== 1'b0 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL ovr_ack got %b/%b exp 0/0", key_valid, overrun);
      end
      held = 16'h0;
      wait_for(1, 1'b0, 80, n, hit);
      checks++;
      if (!hit || key_valid !== 1'b0) begin
         errors++;
         $display("FAIL ovr_release got %b hit %0d exp 0", key_valid, hit);
      end
   endtask

   task automatic test_ack_collision();
      int n;
      bit hit;
      held = 16'h0002;
      wait_for(0, 1'b1, 80, n, hit);
      checks++;
      if (!hit || key_code !== 4'h2) begin
         errors++;
         $display("FAIL col_press2 got %h hit %0d exp 2", key_code, hit);
      end
      held = 16'h0;
      wait_for(1, 1'b0, 80, n, hit);
      held = 16'h4000;
      wait_for(1, 1'b1, 80, n, hit);
      pulse_ack();
      checks++;
      if (!hit || key_code !== 4'hF || key_valid !== 1'b1 ||
          overrun !== 1'b0) begin
         errors++;
         $display("FAIL col_pressF got %h/%b/%b exp F/1/0",
                  key_code, key_valid, overrun);
      end
      ticks(2);
      checks++;
      if (key_valid !== 1'b1) begin
         errors++;
         $display("FAIL col_hold got %b exp 1", key_valid);
      end
      pulse_ack();
      held = 16'h0;
      wait_for(1, 1'b0, 80, n, hit);
   endtask

   task automatic test_mid_reset();
      int n;
      bit hit;
      held = 16'h8000;
      wait_for(0, 1'b1, 80, n, hit);
      checks++;
      if (!hit || key_code !== 4'hD || key_pressed !== 1'b1) begin
         errors++;
         $display("FAIL mr_pressD got %h/%b exp D/1",
                  key_code, key_pressed);
      end
      reset = 1'b0;
      ticks(2);
      checks++;
      if ({key_code, key_valid, key_pressed, overrun} !== 7'd0 ||
          row_n !== 4'b1110) begin
         errors++;
         $display("FAIL mr_clear got %h%b%b%b row %b exp 0000 1110",
                  key_code, key_valid, key_pressed, overrun, row_n);
      end
      reset = 1'b1;
      wait_for(0, 1'b1, 80, n, hit);
      checks++;
      if (!hit || n < 30 || n > 40) begin
         errors++;
         $display("FAIL mr_rereport got %0d hit %0d exp 30..40", n, hit);
      end
      checks++;
      if (key_code !== 4'hD) begin
         errors++;
         $display("FAIL mr_code got %h exp D", key_code);
      end
      pulse_ack();
      held = 16'h0;
      ticks(40);
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_bounce();
      test_multi();
      test_overrun();
      test_ack_collision();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
